// File: rtl/seg_scan_pkg.sv
// Shared constants for the 3-digit 7-segment scan bus: digit count, active-low segment
// patterns {dp,g,f,e,d,c,b,a} with dp inactive, and the receive FSM state encoding.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSettle  = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StHold    = 2'd3;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational active-low g..a pattern to hex nibble decoder; dp is ignored.
module seg7_pattern_decoder
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic [3:0] hex_o
);

  logic [7:0] seg_full;

  // Force dp inactive so the pattern compares directly against the SEG_x constants.
  always_comb begin
    seg_full = {1'b1, seg_i};
    legal_o  = 1'b1;
    hex_o    = 4'h0;
    case (seg_full)
      SEG_0:   hex_o = 4'h0;
      SEG_1:   hex_o = 4'h1;
      SEG_2:   hex_o = 4'h2;
      SEG_3:   hex_o = 4'h3;
      SEG_4:   hex_o = 4'h4;
      SEG_5:   hex_o = 4'h5;
      SEG_6:   hex_o = 4'h6;
      SEG_7:   hex_o = 4'h7;
      SEG_8:   hex_o = 4'h8;
      SEG_9:   hex_o = 4'h9;
      SEG_A:   hex_o = 4'hA;
      SEG_B:   hex_o = 4'hB;
      SEG_C:   hex_o = 4'hC;
      SEG_D:   hex_o = 4'hD;
      SEG_E:   hex_o = 4'hE;
      SEG_F:   hex_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/time_demultiplexer.sv
// Receive end of the 3-digit 7-seg scan bus: registers the bus, waits for each digit to be
// stable for STABLE_CYCLES samples, decodes it and holds the recovered nibbles on out1..out3.
// Optional: define TIME_DEMUX_ERR_CNT_EN to add err_count, a saturating count of decode_err.
module time_demultiplexer
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] anode,
  input  logic [7:0]            cathode,
  output logic [7:0]            out1,
  output logic [7:0]            out2,
  output logic [7:0]            out3,
  output logic [NUM_DIGITS-1:0] digit_valid,
  output logic                  frame_done,
`ifdef TIME_DEMUX_ERR_CNT_EN
  output logic                  decode_err,
  output logic [7:0]            err_count
`else
  output logic                  decode_err
`endif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]        anode_q;
  logic [7:0]                   cathode_q;
  logic                         chg_d, chg_q;
  logic [CntW-1:0]              cnt_d, cnt_q;
  logic [1:0]                   state_d, state_q;
  logic [NUM_DIGITS-1:0][7:0]   out_d, out_q;
  logic [NUM_DIGITS-1:0]        valid_d, valid_q;
  logic [NUM_DIGITS-1:0]        mask_d, mask_q, mask_next;
  logic                         fd_d, fd_q;
  logic                         err_d, err_q;

  logic                         same;
  logic                         onehot;
  logic [1:0]                   sel;
  logic                         stable;
  logic [1:0]                   scan_next;
  logic                         legal;
  logic [3:0]                   hex;

  seg7_pattern_decoder u_dec (
    .seg_i   (cathode_q[6:0]),
    .legal_o (legal),
    .hex_o   (hex)
  );

  // Stability tracking: chg_q flags that the registered sample just changed, cnt_q counts
  // consecutive identical samples and saturates at STABLE_CYCLES.
  always_comb begin
    same  = (anode == anode_q) && (cathode == cathode_q);
    chg_d = !same;
    if (!same) begin
      cnt_d = CntW'(1);
    end else if (cnt_q >= CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Digit select from the registered anode; anything but a single low bit is not one-hot.
  always_comb begin
    onehot = 1'b1;
    sel    = 2'd0;
    case (anode_q)
      3'b110:  sel = 2'd0;
      3'b101:  sel = 2'd1;
      3'b011:  sel = 2'd2;
      default: onehot = 1'b0;
    endcase
    stable = (cnt_q == CntMax);
    // Where a freshly changed or still-settling sample leads; multi-anode samples also reach
    // CAPTURE once stable so they can be flagged there.
    if (anode_q == '1) begin
      scan_next = StIdle;
    end else if (stable) begin
      scan_next = StCapture;
    end else if (onehot) begin
      scan_next = StSettle;
    end else begin
      scan_next = StIdle;
    end
  end

  // FSM next state, capture writes and frame tracking.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = valid_q;
    mask_d    = mask_q;
    mask_next = mask_q;
    fd_d      = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      StIdle, StSettle: state_d = scan_next;
      StCapture: begin
        if (chg_q) begin
          // Sample moved during the capture cycle: abandon and re-settle.
          state_d = scan_next;
        end else begin
          state_d = StHold;
          if (onehot && legal) begin
            out_d[sel]   = {4'b0, hex};
            valid_d[sel] = 1'b1;
            mask_next    = mask_q | (NUM_DIGITS'(1) << sel);
            if (mask_next == '1) begin
              fd_d   = 1'b1;
              mask_d = '0;
            end else begin
              mask_d = mask_next;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (chg_q) begin
          state_d = scan_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_q   <= '1;
      cathode_q <= SEG_BLANK;
      chg_q     <= 1'b0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      out_q     <= '0;
      valid_q   <= '0;
      mask_q    <= '0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      anode_q   <= anode;
      cathode_q <= cathode;
      chg_q     <= chg_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      mask_q    <= mask_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

`ifdef TIME_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;

  // Saturating count of decode_err pulses, updated together with the pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign out1        = out_q[0];
  assign out2        = out_q[1];
  assign out3        = out_q[2];
  assign digit_valid = valid_q;
  assign frame_done  = fd_q;
  assign decode_err  = err_q;

endmodule
